// File: rtl/pc_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl_if
// Description : Fetch request/response bus between pc_fetch_ctrl and the
//               channel arbiter / ibuffer side.
//               master : driven by pc_fetch_ctrl
//                        (req_valid, req_addr, resp_pc, resp_stale out;
//                         req_ready, resp_valid in)
//               slave  : the opposite direction for the consumer side
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 64
) ();
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [ADDR_W-1:0] resp_pc;
    logic              resp_stale;

    modport master (
        output req_valid, req_addr, resp_pc, resp_stale,
        input  req_ready, resp_valid
    );

    modport slave (
        input  req_valid, req_addr, resp_pc, resp_stale,
        output req_ready, resp_valid
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : Sequential fetch-address generator with up to MAX_OUTSTANDING
//               requests in flight. An in-order tracking FIFO keeps the
//               address and a wrong-path (stale) flag for each request; a
//               redirect marks everything in flight stale so the ibuffer
//               can drop those responses.
// Ports       : clock, reset_n (async, active-low)
//               boot_addr        - PC loaded at reset
//               redirect_valid / redirect_target - redirect pulse and PC
//               fetch_inst       - ibuffer has room (level)
//               bus (master)     - req_valid/req_addr/req_ready,
//                                  resp_valid/resp_pc/resp_stale
//               pc               - next expected correct-path PC
//               outstanding      - in-flight request count
//               err_resp_empty   - sticky: response seen with FIFO empty
// Options     : define PC_FETCH_CTRL_PERF_EN to add the saturating counters
//               perf_req_cnt, perf_stale_cnt, perf_credit_stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter  int unsigned ADDR_W          = 64,
    parameter  int unsigned FETCH_BYTES     = 8,
    parameter  int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned c_CNT_W         = $clog2(MAX_OUTSTANDING) + 1
) (
    input  wire logic               clock,
    input  wire logic               reset_n,
    input  wire logic [ADDR_W-1:0]  boot_addr,
    input  wire logic               redirect_valid,
    input  wire logic [ADDR_W-1:0]  redirect_target,
    input  wire logic               fetch_inst,
    pc_fetch_ctrl_if.master         bus,
    output logic      [ADDR_W-1:0]  pc,
    output logic      [c_CNT_W-1:0] outstanding,
    output logic                    err_resp_empty
`ifdef PC_FETCH_CTRL_PERF_EN
    ,
    output logic      [31:0]        perf_req_cnt,
    output logic      [31:0]        perf_stale_cnt,
    output logic      [31:0]        perf_credit_stall_cnt
`endif
);

    localparam int unsigned        c_PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [ADDR_W-1:0]  c_STEP       = ADDR_W'(FETCH_BYTES);
    localparam logic [ADDR_W-1:0]  c_ALIGN_MASK = ~(c_STEP - ADDR_W'(1));
    localparam logic [c_PTR_W-1:0] c_PTR_LAST   = c_PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [c_CNT_W:0]   c_MAX_EXT    = (c_CNT_W + 1)'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [c_CNT_W-1:0]   cnt_q;
    logic                 err_q;

    logic [ADDR_W-1:0]    fifo_addr_q [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] fifo_stale_q;
    logic [c_PTR_W-1:0]   wr_ptr_q, rd_ptr_q;

    logic                 w_hs;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_room;
    logic                 w_resp_stale;
    logic [c_CNT_W:0]     w_cnt_nxt;
    logic [ADDR_W-1:0]    w_head_addr;
    logic                 w_head_stale;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + c_PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Handshake, credit accounting and response view
    // ------------------------------------------------------------------
    assign w_hs         = bus.req_valid & bus.req_ready;
    assign w_empty      = (cnt_q == '0);
    assign w_pop        = bus.resp_valid & ~w_empty;
    // One bit wider than the counter so the intermediate sum cannot wrap.
    assign w_cnt_nxt    = {1'b0, cnt_q} + (c_CNT_W + 1)'(w_hs) - (c_CNT_W + 1)'(w_pop);
    assign w_room       = (w_cnt_nxt < c_MAX_EXT);
    assign w_head_addr  = fifo_addr_q[rd_ptr_q];
    assign w_head_stale = fifo_stale_q[rd_ptr_q];
    // A redirect in the same cycle as the response wins: the data is wrong-path.
    assign w_resp_stale = bus.resp_valid & (w_head_stale | redirect_valid);

    assign bus.req_valid  = (state_q == ST_REQ);
    assign bus.req_addr   = req_addr_q;
    assign bus.resp_pc    = w_head_addr;
    assign bus.resp_stale = w_resp_stale;

    assign pc             = pc_q;
    assign outstanding    = cnt_q;
    assign err_resp_empty = err_q;

    // ------------------------------------------------------------------
    // Request FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Request FSM: next state, next request address, next pc
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        pc_d       = pc_q;

        if (redirect_valid) begin
            // A redirect forces a fetch regardless of ibuffer space.
            req_addr_d = redirect_target;
            state_d    = w_room ? ST_REQ : ST_IDLE;
        end else if (state_q == ST_REQ) begin
            if (w_hs) begin
                // Aligning here makes only the first post-redirect request unaligned.
                req_addr_d = (req_addr_q & c_ALIGN_MASK) + c_STEP;
                state_d    = (fetch_inst & w_room) ? ST_REQ : ST_IDLE;
            end
        end else if (fetch_inst & w_room) begin
            state_d = ST_REQ;
        end

        if (redirect_valid) begin
            pc_d = redirect_target;
        end else if (w_pop & ~w_resp_stale) begin
            pc_d = (w_head_addr & c_ALIGN_MASK) + c_STEP;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers and tracking FIFO control
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_addr_q   <= boot_addr;
            pc_q         <= boot_addr;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_stale_q <= '0;
        end else begin
            req_addr_q <= req_addr_d;
            pc_q       <= pc_d;
            cnt_q      <= w_cnt_nxt[c_CNT_W-1:0];

            if (bus.resp_valid & w_empty) begin
                err_q <= 1'b1;
            end

            // Marking empty slots too is harmless: a push rewrites its flag.
            if (redirect_valid) begin
                fifo_stale_q <= '1;
            end
            if (w_hs) begin
                fifo_stale_q[wr_ptr_q] <= redirect_valid;
                wr_ptr_q               <= ptr_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // Address storage needs no reset; the count qualifies every read.
    always_ff @(posedge clock) begin
        if (w_hs) begin
            fifo_addr_q[wr_ptr_q] <= req_addr_q;
        end
    end

`ifdef PC_FETCH_CTRL_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic w_credit_stall;
    assign w_credit_stall = fetch_inst & ~bus.req_valid
                          & (cnt_q == c_CNT_W'(MAX_OUTSTANDING));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_req_cnt          <= '0;
            perf_stale_cnt        <= '0;
            perf_credit_stall_cnt <= '0;
        end else begin
            if (w_hs && (perf_req_cnt != '1)) begin
                perf_req_cnt <= perf_req_cnt + 32'd1;
            end
            if (bus.resp_valid && w_resp_stale && (perf_stale_cnt != '1)) begin
                perf_stale_cnt <= perf_stale_cnt + 32'd1;
            end
            if (w_credit_stall && (perf_credit_stall_cnt != '1)) begin
                perf_credit_stall_cnt <= perf_credit_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Parametrised successor to the single-request PC controller in the frontend. It generates sequential fetch addresses toward channel_arb and allows up to MAX_OUTSTANDING requests in flight. An in-order tracking FIFO holds the address and a stale flag for each in-flight request. On redirect, every in-flight request is marked stale; its response is then flagged for the ibuffer to drop, while the response's PC is still reported.

Parameters:
ADDR_W, 64, width of all addresses
FETCH_BYTES, 8, bytes per fetch (power of 2, >=2); OFS = log2(FETCH_BYTES)
MAX_OUTSTANDING, 4, tracking FIFO depth (power of 2, >=1)

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous active-low reset
boot_addr  in  ADDR_W  PC loaded at reset
redirect_valid  in  1  redirect pulse from pju
redirect_target  in  ADDR_W  redirect PC
fetch_inst  in  1  ibuffer has room (level)
req_valid  out  1  fetch request valid
req_addr  out  ADDR_W  fetch address
req_ready  in  1  channel_arb accepts request
resp_valid  in  1  fetch data returned (strictly in request order)
resp_pc  out  ADDR_W  address of the returning request (FIFO head)
resp_stale  out  1  returning data is wrong-path; ibuffer drops it
pc  out  ADDR_W  next expected correct-path PC
outstanding  out  log2(MAX_OUTSTANDING)+1  in-flight count
err_resp_empty  out  1  sticky: resp_valid arrived with FIFO empty

Behaviour:
- Reset is asynchronous, active-low; clock is clock. Reset values:
  - req_valid=0, req_addr=boot_addr, pc=boot_addr.
  - outstanding=0, FIFO empty, err_resp_empty=0.
- Definitions:
  - hs = req_valid & req_ready.
  - pop = resp_valid & FIFO not empty.
  - cnt_nxt = outstanding + hs - pop.
  - room = cnt_nxt < MAX_OUTSTANDING.
  - align(x) = x with bits [OFS-1:0] cleared.
- Request FSM, two states:
  - IDLE: req_valid=0.
  - REQ: req_valid=1; req_addr held stable until hs or redirect.
- Transitions, priority order:
  1. redirect_valid:
     - req_addr<=redirect_target.
     - next state = REQ if room, else IDLE.
     - fetch_inst is ignored for this decision (a redirect forces a fetch).
  2. REQ & hs:
     - req_addr<=align(req_addr)+FETCH_BYTES, wrapping modulo 2^ADDR_W.
     - next state = REQ if fetch_inst & room, else IDLE.
  3. REQ & ~hs: remain in REQ.
  4. IDLE: go to REQ when fetch_inst & room (address unchanged).
- The first request after a redirect carries the unaligned target. All later requests are aligned.
- Tracking FIFO:
  - On hs, push {req_addr, stale=redirect_valid}. A request handshaken in the same cycle as a redirect is wrong-path.
  - On pop, remove the head.
  - Push and pop in the same cycle are legal at any fill level, including full.
  - A pop occurs only on resp_valid; the FIFO can never overflow because room gates the request.
- On redirect_valid, set the stale bit of every valid FIFO entry at that edge.
- Response outputs (combinational):
  - resp_pc = head address.
  - resp_stale = resp_valid & (head.stale | redirect_valid); redirect wins on a same-cycle collision.
- pc update:
  - redirect -> redirect_target.
  - else pop & ~resp_stale -> align(head address)+FETCH_BYTES.
  - else hold.
- outstanding <= cnt_nxt. Stale entries continue to consume credits until their response returns.
- resp_valid with the FIFO empty: ignored (no pop, no pc change); err_resp_empty sets and stays 1 until reset.
- Reset asserted mid-operation: all state clears immediately. Responses arriving after reset release hit the empty FIFO and set err_resp_empty.

Optional Feature:
Macro: PC_FETCH_CTRL_PERF_EN.
- When defined, three 32-bit saturating counters are added, reset to 0:
  - perf_req_cnt: counts hs.
  - perf_stale_cnt: counts resp_valid & resp_stale.
  - perf_credit_stall_cnt: counts cycles with fetch_inst & ~req_valid & (outstanding==MAX_OUTSTANDING).
- Each is exposed as an extra 32-bit output port of the same name.
- When not defined, neither the ports nor the logic exist, and all other behaviour is identical.

Test Plan:
- Boot, no redirect:
  - Stimulus: boot_addr=0x1004, fetch_inst=1, req_ready=1, no responses.
  - Response: req_addr 0x1004, 0x1008, 0x1010, 0x1018; then req_valid=0 with outstanding=4 (credit stall).
- Returns after credit stall:
  - Stimulus: from the previous state, 4 resp_valid pulses.
  - Response: resp_pc 0x1004/0x1008/0x1010/0x1018, all resp_stale=0, final pc=0x1020; requests resume at 0x1020.
- Redirect with 2 in flight:
  - Stimulus: redirect_target=0x8002.
  - Response: next req_addr=0x8002; the next two responses have resp_stale=1 and pc stays 0x8002; the third response has resp_pc=0x8002, stale=0, pc=0x8008.
- Same-cycle collisions:
  - Redirect coincident with hs: the pushed entry's response has resp_stale=1.
  - Redirect coincident with resp_valid: resp_stale=1 and pc=redirect_target.
- Backpressure and full FIFO:
  - req_ready=0 for 5 cycles: req_valid and req_addr held stable.
  - Full FIFO with push and pop in the same cycle: outstanding stays at 4.
- Error and reset:
  - Stimulus: resp_valid with outstanding=0.
  - Response: err_resp_empty=1 and sticky; pc unchanged.
  - Stimulus: reset asserted mid-stream. Response: all outputs return to reset values asynchronously.
